bus_arbiter_rr: RTL and testbench
=================================

BUS_ARBITER_RR -- requirements
Module: bus_arbiter_rr

Interface
REQ-001 The block SHALL have parameter NMASTER, default 4, meaning number of bus masters (2..16).
REQ-002 The block SHALL have parameter MAXHOLD, default 16, meaning maximum grant tenure in cycles; 0 means unlimited.
REQ-003 The block SHALL have parameter IDW, default $clog2(NMASTER), meaning owner index width.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 breq_  input  NMASTER  per-master bus request, active-low.
REQ-007 block_  input  NMASTER  per-master lock, active-low; blocks preemption of that master while granted.
REQ-008 bgrt_  output  NMASTER  per-master bus grant, active-low, registered, one-hot-low or all-high.
REQ-009 owner  output  IDW  index of granted master; valid only while busy.
REQ-010 busy  output  1  high while any grant is asserted.
REQ-011 preempt  output  1  one-cycle pulse when a grant is revoked by tenure limit.

Function
REQ-012 States SHALL be IDLE, GRANT, RELEASE.
REQ-013 IDLE: if any breq_ bit low, the arbiter SHALL select the first requester searching from ptr+1 upward modulo NMASTER, assert its bgrt_ on the next edge, load owner, go to GRANT.
REQ-014 IDLE with no request SHALL hold all bgrt_ high and stay in IDLE.
REQ-015 Grant latency SHALL be exactly one cycle from request sampled low in IDLE to bgrt_ low.
REQ-016 GRANT: tenure counter SHALL increment each cycle, saturating at MAXHOLD-1.
REQ-017 GRANT: when breq_[owner] sampled high, bgrt_ SHALL deassert on the next edge and state SHALL go to RELEASE.
REQ-018 GRANT with MAXHOLD!=0: when counter equals MAXHOLD-1, block_[owner] high and another breq_ bit low, bgrt_ SHALL deassert next edge, preempt SHALL pulse for that one cycle, state SHALL go to RELEASE.
REQ-019 Tenure limit reached with no other requester or block_[owner] low SHALL keep the grant; preemption SHALL occur on the first later cycle both conditions clear.
REQ-020 On leaving GRANT, ptr SHALL be set to owner so the departed master has lowest priority next round.
REQ-021 RELEASE SHALL last exactly one cycle with all bgrt_ high (bus turnaround) then go to IDLE; requests sampled in RELEASE are ignored.
REQ-022 Minimum gap between two different grants SHALL be two cycles (RELEASE + IDLE arbitration).
REQ-023 Simultaneous release and tenure expiry SHALL be treated as release; preempt SHALL not pulse.
REQ-024 At most one bgrt_ bit SHALL be low in any cycle.
REQ-025 busy SHALL equal ~&bgrt_; owner SHALL hold its last value when not busy.

Reset
REQ-026 reset high at a clock edge SHALL force state IDLE, bgrt_ all ones, owner 0, busy 0, preempt 0, counter 0, ptr NMASTER-1 (master 0 wins first).
REQ-027 Reset mid-grant SHALL drop the grant on that edge with no RELEASE cycle and no preempt pulse.

Structure
REQ-028 State encoding, Enable_/Disable_ polarity constants and default MAXHOLD SHALL live in the shared define header/package.
REQ-029 The rotating priority search SHALL be a sub-module rr_pick (combinational: request vector, pointer -> index, valid).
REQ-030 The block SHALL replace the fixed two-master arbiter in top, driving dut0..dutN-1 grants to sram0.

Verification
REQ-031 Reset, then breq_=4'b1110 held -> bgrt_=4'b1110 one cycle after first sample, owner=0, busy=1.
REQ-032 breq_=4'b0000 held, block_ all high, MAXHOLD=16 -> grants rotate 0,1,2,3,0 each lasting 16 cycles, preempt pulses each rotation, 1-cycle all-high gap plus 1 arbitration cycle between.
REQ-033 Master 2 granted with block_[2]=0, master 0 requesting -> grant kept past 16 cycles, no preempt; block_[2]->1 -> preempt next cycle.
REQ-034 Master 1 releases at tenure cycle 15 while master 3 requests -> RELEASE, no preempt, master 3 granted 2 cycles later.
REQ-035 reset asserted while master 1 granted -> bgrt_=4'b1111 same edge; next grant goes to master 0 if requesting.
REQ-036 Full dual-MIPS program run with NMASTER=2 -> both dut0 and dut1 store 7 to address 20; one-hot-low assertion never fires.

Source files
------------

// File: rtl/bus_arbiter_rr_pkg.sv
// Shared definitions for the round-robin bus arbiter: FSM states, the polarity
// of the active-low bus strobes, and the default tenure limit.
package bus_arbiter_rr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_e;

  // Bus request/grant/lock strobes are all active-low.
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  localparam int DEFAULT_MAXHOLD = 16;

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Rotating-priority picker: returns the first active request found searching
// upward from ptr_i+1, wrapping modulo N.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  always_comb begin
    logic [IW:0] pos;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = 1; i <= N; i++) begin
      // One spare bit holds ptr+i before the modulo-N wrap.
      pos = {1'b0, ptr_i} + (IW + 1)'(i);
      if (pos >= (IW + 1)'(N)) pos = pos - (IW + 1)'(N);
      if (!valid_o && req_i[pos[IW-1:0]]) begin
        valid_o = 1'b1;
        idx_o   = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin bus arbiter with active-low request/grant/lock strobes, a
// registered one-hot-low grant, a one-cycle turnaround and tenure-limit preemption.
module bus_arbiter_rr
  import bus_arbiter_rr_pkg::*;
#(
  parameter int NMASTER = 4,
  parameter int MAXHOLD = DEFAULT_MAXHOLD,
  parameter int IDW     = $clog2(NMASTER)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NMASTER-1:0] breq_,
  input  logic [NMASTER-1:0] block_,
  output logic [NMASTER-1:0] bgrt_,
  output logic [IDW-1:0]     owner,
  output logic               busy,
  output logic               preempt
);

  localparam int              CW      = (MAXHOLD > 1) ? $clog2(MAXHOLD) : 1;
  localparam logic [CW-1:0]   CNT_MAX = CW'((MAXHOLD > 0) ? MAXHOLD - 1 : 0);
  localparam logic [IDW-1:0]  PTR_RST = IDW'(NMASTER - 1);

  arb_state_e         state_q, state_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [IDW-1:0]     owner_q, owner_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NMASTER-1:0] bgrt_q, bgrt_d;
  logic               preempt_q, preempt_d;

  logic [NMASTER-1:0] req_vec;
  logic [IDW-1:0]     pick_idx;
  logic               pick_valid;

  assign req_vec = ~breq_;

  rr_pick #(
    .N  (NMASTER),
    .IW (IDW)
  ) u_pick (
    .req_i   (req_vec),
    .ptr_i   (ptr_q),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  always_comb begin
    logic [NMASTER-1:0] owner_oh;
    logic               owner_released;
    logic               others_waiting;
    logic               can_preempt;

    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    bgrt_d    = bgrt_q;
    preempt_d = 1'b0;

    owner_oh          = '0;
    owner_oh[owner_q] = 1'b1;
    owner_released    = (breq_[owner_q] == DISABLE_);
    others_waiting    = |(req_vec & ~owner_oh);
    // Lock strobe low means the owner may not be preempted.
    can_preempt       = (MAXHOLD != 0) && (cnt_q == CNT_MAX) &&
                        (block_[owner_q] == DISABLE_) && others_waiting;

    case (state_q)
      ST_IDLE: begin
        bgrt_d = {NMASTER{DISABLE_}};
        cnt_d  = '0;
        if (pick_valid) begin
          bgrt_d[pick_idx] = ENABLE_;
          owner_d          = pick_idx;
          state_d          = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        // A voluntary release takes precedence over a simultaneous tenure expiry.
        if (owner_released || can_preempt) begin
          bgrt_d    = {NMASTER{DISABLE_}};
          ptr_d     = owner_q;
          preempt_d = !owner_released;
          state_d   = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        bgrt_d  = {NMASTER{DISABLE_}};
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        bgrt_d  = {NMASTER{DISABLE_}};
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ptr_q     <= PTR_RST;
      owner_q   <= '0;
      cnt_q     <= '0;
      bgrt_q    <= {NMASTER{DISABLE_}};
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      bgrt_q    <= bgrt_d;
      preempt_q <= preempt_d;
    end
  end

  assign bgrt_   = bgrt_q;
  assign owner   = owner_q;
  assign busy    = ~&bgrt_q;
  assign preempt = preempt_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench for bus_arbiter_rr (4 masters, 16-cycle tenure limit).
module tb_bus_arbiter_rr;

  logic       clk;
  logic       reset;
  logic [3:0] breq_;
  logic [3:0] block_;
  logic [3:0] bgrt_;
  logic [1:0] owner;
  logic       busy;
  logic       preempt;

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;

  bus_arbiter_rr #(
    .NMASTER (4),
    .MAXHOLD (16),
    .IDW     (2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .breq_   (breq_),
    .block_  (block_),
    .bgrt_   (bgrt_),
    .owner   (owner),
    .busy    (busy),
    .preempt (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Continuous invariants: grant is one-hot-low or all-high, busy tracks it.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (!($countones(~bgrt_) <= 1) || (busy !== ~&bgrt_)) begin
        errors++;
        $display("FAIL onehot_busy: bgrt_=%b busy=%b", bgrt_, busy);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    breq_  = 4'b1111;
    block_ = 4'b1111;
    tick(2);
    reset  = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    mon_en = 1'b1;
    checks++;
    if (bgrt_ !== 4'b1111) begin errors++; $display("FAIL reset_bgrt: got %b exp 1111", bgrt_); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
    checks++;
    if (preempt !== 1'b0) begin errors++; $display("FAIL reset_preempt: got %b exp 0", preempt); end
    checks++;
    if (owner !== 2'd0) begin errors++; $display("FAIL reset_owner: got %0d exp 0", owner); end
  endtask

  task automatic test_first_grant();
    do_reset();
    breq_ = 4'b1110;
    tick(1);
    checks++;
    if (bgrt_ !== 4'b1110) begin errors++; $display("FAIL first_grant_bgrt: got %b exp 1110", bgrt_); end
    checks++;
    if (owner !== 2'd0) begin errors++; $display("FAIL first_grant_owner: got %0d exp 0", owner); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL first_grant_busy: got %b exp 1", busy); end
    breq_ = 4'b1111;
    tick(1);
    checks++;
    if (bgrt_ !== 4'b1111 || preempt !== 1'b0) begin
      errors++; $display("FAIL release_drop: bgrt_=%b preempt=%b exp 1111/0", bgrt_, preempt);
    end
    tick(2);
  endtask

  task automatic test_rotation();
    logic [3:0] exp_g;
    int         len;
    do_reset();
    breq_ = 4'b0000;
    tick(1);
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b1111;
      exp_g[k % 4] = 1'b0;
      checks++;
      if (bgrt_ !== exp_g || owner !== 2'(k % 4)) begin
        errors++; $display("FAIL rot_grant%0d: bgrt_=%b owner=%0d exp %b/%0d", k, bgrt_, owner, exp_g, k % 4);
      end
      len = 0;
      while (busy === 1'b1 && len < 40) begin
        len++;
        tick(1);
      end
      checks++;
      if (len != 16) begin errors++; $display("FAIL rot_tenure%0d: got %0d cycles exp 16", k, len); end
      checks++;
      if (preempt !== 1'b1) begin errors++; $display("FAIL rot_preempt%0d: got %b exp 1", k, preempt); end
      if (k == 4) breq_ = 4'b1111;
      tick(1);
      checks++;
      if (bgrt_ !== 4'b1111 || preempt !== 1'b0) begin
        errors++; $display("FAIL rot_gap%0d: bgrt_=%b preempt=%b exp 1111/0", k, bgrt_, preempt);
      end
      tick(1);
    end
    tick(2);
  endtask

  task automatic test_lock();
    int bad;
    do_reset();
    breq_  = 4'b1011;
    block_ = 4'b1011;
    tick(1);
    checks++;
    if (bgrt_ !== 4'b1011) begin errors++; $display("FAIL lock_grant: got %b exp 1011", bgrt_); end
    breq_ = 4'b1010;
    bad = 0;
    repeat (20) begin
      tick(1);
      if (bgrt_ !== 4'b1011 || preempt !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL lock_hold: %0d bad cycles exp 0", bad); end
    block_ = 4'b1111;
    tick(1);
    checks++;
    if (bgrt_ !== 4'b1111 || preempt !== 1'b1) begin
      errors++; $display("FAIL lock_preempt: bgrt_=%b preempt=%b exp 1111/1", bgrt_, preempt);
    end
    tick(2);
    checks++;
    if (bgrt_ !== 4'b1110 || owner !== 2'd0) begin
      errors++; $display("FAIL lock_next: bgrt_=%b owner=%0d exp 1110/0", bgrt_, owner);
    end
    breq_ = 4'b1111;
    tick(4);
  endtask

  task automatic test_release_at_limit();
    do_reset();
    breq_ = 4'b1101;
    tick(1);
    breq_ = 4'b0101;
    tick(15);
    checks++;
    if (bgrt_ !== 4'b1101) begin errors++; $display("FAIL limit_hold: got %b exp 1101", bgrt_); end
    breq_ = 4'b0111;
    tick(1);
    checks++;
    if (bgrt_ !== 4'b1111 || preempt !== 1'b0) begin
      errors++; $display("FAIL limit_release: bgrt_=%b preempt=%b exp 1111/0", bgrt_, preempt);
    end
    tick(1);
    checks++;
    if (bgrt_ !== 4'b1111) begin errors++; $display("FAIL limit_gap: got %b exp 1111", bgrt_); end
    tick(1);
    checks++;
    if (bgrt_ !== 4'b0111 || owner !== 2'd3) begin
      errors++; $display("FAIL limit_next: bgrt_=%b owner=%0d exp 0111/3", bgrt_, owner);
    end
    breq_ = 4'b1111;
    tick(4);
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    breq_ = 4'b1101;
    tick(1);
    checks++;
    if (bgrt_ !== 4'b1101) begin errors++; $display("FAIL midrst_grant: got %b exp 1101", bgrt_); end
    breq_ = 4'b1100;
    tick(3);
    reset = 1'b1;
    tick(1);
    checks++;
    if (bgrt_ !== 4'b1111 || busy !== 1'b0 || preempt !== 1'b0 || owner !== 2'd0) begin
      errors++;
      $display("FAIL midrst_drop: bgrt_=%b busy=%b preempt=%b owner=%0d exp 1111/0/0/0",
               bgrt_, busy, preempt, owner);
    end
    reset = 1'b0;
    tick(1);
    checks++;
    if (bgrt_ !== 4'b1110 || owner !== 2'd0) begin
      errors++; $display("FAIL midrst_next: bgrt_=%b owner=%0d exp 1110/0", bgrt_, owner);
    end
    breq_ = 4'b1111;
    tick(4);
  endtask

  initial begin
    reset  = 1'b1;
    breq_  = 4'b1111;
    block_ = 4'b1111;
    test_reset();
    test_first_grant();
    test_rotation();
    test_lock();
    test_release_at_limit();
    test_reset_mid_grant();
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
